cache_miss_ctrl: RTL
====================

# cache_miss_ctrl

Miss handler for the 4-way, 16-set, 32-byte-line data cache. On a lookup miss it captures the PLRU-selected victim way, writes the victim line back to the downstream memory port if it is valid and dirty, fetches the missing line, and issues a one-cycle fill into the tag/data arrays. It sits directly downstream of the PLRU replacement logic, consuming its victim-way output, and upstream of the DFP (memory-side) port. The cache lookup then retries, hits, and updates PLRU.

## Interface
- Parameters: none. Geometry is fixed:
  - 32-bit address, 5 offset bits, 4 set bits, 23 tag bits.
  - 256-bit line, 4 ways.
- Reset is synchronous and active-high (rst). Clock is clk.
- Ports:
  - clk  in  1  clock
  - rst  in  1  synchronous active-high reset
  - miss_req  in  1  lookup missed; set/tag valid this cycle
  - miss_set  in  4  set index of missing address
  - miss_tag  in  23  tag of missing address
  - ready  out  1  high only in IDLE; miss_req accepted only when ready
  - victim_way  in  2  PLRU replacement way for the set presented last cycle
  - victim_valid  in  1  valid bit of that way, from the arrays (1-cycle read latency)
  - victim_dirty  in  1  dirty bit of that way
  - victim_tag  in  23  tag of that way
  - victim_data  in  256  line data of that way
  - meta_set  out  4  set driven to arrays/PLRU for the victim read
  - dfp_addr  out  32  line-aligned memory address
  - dfp_read  out  1  memory read request
  - dfp_write  out  1  memory write request
  - dfp_wdata  out  256  writeback data
  - dfp_rdata  in  256  fetched line, valid with dfp_resp
  - dfp_resp  in  1  memory completion, one cycle
  - fill_we  out  1  write enable into tag/data arrays
  - fill_way  out  2  way to write
  - fill_set  out  4  set to write
  - fill_tag  out  23  tag to write; valid bit set, dirty bit cleared
  - fill_data  out  256  line to write
  - wb_count  out  16  saturating count of writebacks issued

## Operation
- **States:** IDLE, CAPTURE, WRITEBACK, FETCH, FILL.
- **IDLE:** ready=1. On miss_req, latch miss_set and miss_tag, then go to CAPTURE. meta_set = miss_set in IDLE; otherwise it equals the latched set.
- **CAPTURE** (one cycle): latch victim_way, victim_valid, victim_dirty, victim_tag and victim_data.
  - If valid && dirty, go to WRITEBACK.
  - Otherwise go to FETCH. A dirty bit on an invalid line is ignored.
  - The victim way is frozen here. Later PLRU changes do not affect this miss.
- **WRITEBACK:**
  - Outputs: dfp_write=1, dfp_addr={victim_tag, set, 5'b0}, dfp_wdata=victim data.
  - All three are held stable until dfp_resp.
  - On dfp_resp, go to FETCH and increment wb_count; it saturates at 16'hFFFF.
- **FETCH:** dfp_read=1, dfp_addr={miss_tag, set, 5'b0}, held until dfp_resp. On dfp_resp, latch dfp_rdata and go to FILL.
- **FILL** (one cycle):
  - fill_we=1.
  - fill_way = latched victim way; fill_set and fill_tag = latched miss values; fill_data = fetched line.
  - Next state is IDLE.
- dfp_read and dfp_write are never both high.
- dfp_resp outside WRITEBACK/FETCH is ignored.
- miss_req while not ready is ignored; the requester holds it.

## Timing
- **Reset values:**
  - state IDLE, ready=1.
  - dfp_read, dfp_write, fill_we = 0.
  - dfp_addr, dfp_wdata, fill_* data fields = 0.
  - wb_count=0.
- **Reset mid-operation:** abandons the miss. Request outputs are low from the cycle after the reset edge, and no fill occurs.
- **Registered outputs:** dfp_* and fill_* are registered, with no combinational path from dfp_resp to dfp_*.
- **Clean miss latency** (miss_req at cycle 0, CAPTURE at cycle 1):
  - dfp_read is high from cycle 2.
  - With dfp_resp in cycle 2+k, fill_we is in cycle 3+k and ready returns in cycle 4+k.
- **Dirty miss:** the WRITEBACK phase adds 1+k_wb cycles before FETCH.
- **Zero-wait response:** dfp_resp in the first cycle of a request is legal.
- **Back-to-back misses:** a miss_req in the ready cycle after FILL is accepted immediately.

## Test plan
- **Clean miss:**
  - Stimulus: miss_set=3, miss_tag=0x12345, victim_valid=0, victim_way=2, dfp_resp 3 cycles after dfp_read.
  - Required: dfp_addr=0x02468A60. One fill_we with way=2, set=3, fill_data=dfp_rdata. wb_count stays 0.
- **Dirty miss:**
  - Stimulus: victim_valid=1, victim_dirty=1, victim_tag=0x00001, set=5.
  - Required: dfp_write with addr=0x000002A0 and victim data. Then dfp_read of the miss address, then fill. wb_count=1.
- **Invalid dirty victim:**
  - Stimulus: victim_valid=0, victim_dirty=1.
  - Required: no dfp_write; goes straight to FETCH.
- **Victim freeze:**
  - Stimulus: victim_way changes from 1 to 3 during FETCH.
  - Required: fill_way=1.
- **Reset during WRITEBACK:**
  - Stimulus: rst asserted while in WRITEBACK.
  - Required: dfp_write=0 the next cycle, ready=1, no fill_we. A later miss completes normally.
- **Stability and ignored responses:**
  - Stimulus: stray dfp_resp in IDLE; 0- and 10-cycle memory latencies.
  - Required: the stray dfp_resp has no effect. dfp_addr and dfp_wdata stay constant while requests are pending.

Source files
------------

// File: rtl/cache_miss_ctrl_if.sv
// Signal bundle between the data-cache miss handler, the tag/data/PLRU arrays
// and the memory-side (DFP) port.
interface cache_miss_ctrl_if;
   logic         miss_req;
   logic [3:0]   miss_set;
   logic [22:0]  miss_tag;
   logic         ready;
   logic [1:0]   victim_way;
   logic         victim_valid;
   logic         victim_dirty;
   logic [22:0]  victim_tag;
   logic [255:0] victim_data;
   logic [3:0]   meta_set;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic         fill_we;
   logic [1:0]   fill_way;
   logic [3:0]   fill_set;
   logic [22:0]  fill_tag;
   logic [255:0] fill_data;
   logic [15:0]  wb_count;

   // master: the miss controller itself
   modport master (
      input  miss_req, miss_set, miss_tag,
      input  victim_way, victim_valid, victim_dirty, victim_tag, victim_data,
      input  dfp_rdata, dfp_resp,
      output ready, meta_set,
      output dfp_addr, dfp_read, dfp_write, dfp_wdata,
      output fill_we, fill_way, fill_set, fill_tag, fill_data,
      output wb_count
   );

   // slave: the cache pipeline, arrays and memory around it
   modport slave (
      output miss_req, miss_set, miss_tag,
      output victim_way, victim_valid, victim_dirty, victim_tag, victim_data,
      output dfp_rdata, dfp_resp,
      input  ready, meta_set,
      input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
      input  fill_we, fill_way, fill_set, fill_tag, fill_data,
      input  wb_count
   );
endinterface

// File: rtl/cache_miss_ctrl.sv
// Miss handler for the 4-way, 16-set, 32-byte-line data cache: captures the
// PLRU victim, writes it back if dirty, fetches the missing line and fills it.
module cache_miss_ctrl (
   input  logic              clk,
   input  logic              rst,
   cache_miss_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      WRITEBACK,
      FETCH,
      FILL
   } state_t;

   state_t      state;
   logic [3:0]  set_q;
   logic [22:0] tag_q;
   logic [1:0]  way_q;

   assign bus.ready    = (state == IDLE);
   // Arrays have one cycle of read latency, so the set is presented in IDLE.
   assign bus.meta_set = (state == IDLE) ? bus.miss_set : set_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         set_q         <= '0;
         tag_q         <= '0;
         way_q         <= '0;
         bus.dfp_addr  <= '0;
         bus.dfp_read  <= 1'b0;
         bus.dfp_write <= 1'b0;
         bus.dfp_wdata <= '0;
         bus.fill_we   <= 1'b0;
         bus.fill_way  <= '0;
         bus.fill_set  <= '0;
         bus.fill_tag  <= '0;
         bus.fill_data <= '0;
         bus.wb_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               bus.fill_we <= 1'b0;
               if (bus.miss_req) begin
                  set_q <= bus.miss_set;
                  tag_q <= bus.miss_tag;
                  state <= CAPTURE;
               end
            end

            CAPTURE: begin
               // Victim way is frozen here; later PLRU updates are not seen.
               way_q <= bus.victim_way;
               if (bus.victim_valid && bus.victim_dirty) begin
                  bus.dfp_write <= 1'b1;
                  bus.dfp_addr  <= {bus.victim_tag, set_q, 5'b0};
                  bus.dfp_wdata <= bus.victim_data;
                  state         <= WRITEBACK;
               end else begin
                  bus.dfp_read <= 1'b1;
                  bus.dfp_addr <= {tag_q, set_q, 5'b0};
                  state        <= FETCH;
               end
            end

            WRITEBACK: begin
               if (bus.dfp_resp) begin
                  bus.dfp_write <= 1'b0;
                  bus.dfp_read  <= 1'b1;
                  bus.dfp_addr  <= {tag_q, set_q, 5'b0};
                  if (bus.wb_count != 16'hFFFF)
                     bus.wb_count <= bus.wb_count + 16'd1;
                  state <= FETCH;
               end
            end

            FETCH: begin
               if (bus.dfp_resp) begin
                  bus.dfp_read  <= 1'b0;
                  bus.fill_we   <= 1'b1;
                  bus.fill_way  <= way_q;
                  bus.fill_set  <= set_q;
                  bus.fill_tag  <= tag_q;
                  bus.fill_data <= bus.dfp_rdata;
                  state         <= FILL;
               end
            end

            FILL: begin
               bus.fill_we <= 1'b0;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule
